// File: rtl/ysyx_040750_pc_fetch.sv
// ysyx_040750_pc_fetch: PC register and single-outstanding
// instruction fetch front end (imem AR/R, IF/ID valid/ready).
module ysyx_040750_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_pc_valid,
  output logic        O_pc_ready,
  input  logic [31:0] I_dnpc,
  input  logic        I_flush,
  output logic [31:0] O_araddr,
  output logic        O_arvalid,
  input  logic        I_arready,
  input  logic [31:0] I_rdata,
  input  logic [1:0]  I_rresp,
  input  logic        I_rvalid,
  output logic        O_rready,
  output logic [31:0] O_pc,
  output logic [31:0] O_snpc,
  output logic [31:0] O_inst,
  output logic        O_fetch_err,
  output logic        O_IF_ID_valid,
  input  logic        I_IF_ID_ready
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_NEXT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic        discard_q, discard_d;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  // State, PC and captured-instruction registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      err_q     <= err_d;
      discard_q <= discard_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    err_d     = err_q;
    discard_d = discard_q;
    unique case (state_q)
      S_REQ: begin
        if (misaligned) begin
          inst_d  = NOP_INST;
          err_d   = 1'b1;
          state_d = I_flush ? S_NEXT : S_OUT;
        end else begin
          if (I_flush) begin
            discard_d = 1'b1;
          end
          if (I_arready) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (I_flush) begin
          discard_d = 1'b1;
        end
        if (I_rvalid) begin
          inst_d  = I_rdata;
          err_d   = |I_rresp;
          state_d = (discard_q || I_flush)
                  ? S_NEXT : S_OUT;
        end
      end
      S_OUT: begin
        if (I_flush || I_IF_ID_ready) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (I_pc_valid) begin
          pc_d      = I_dnpc;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Moore handshake outputs
  always_comb begin
    O_arvalid     = 1'b0;
    O_rready      = 1'b0;
    O_IF_ID_valid = 1'b0;
    O_pc_ready    = 1'b0;
    unique case (state_q)
      S_REQ:   O_arvalid     = !misaligned;
      S_WAIT:  O_rready      = 1'b1;
      S_OUT:   O_IF_ID_valid = 1'b1;
      S_NEXT:  O_pc_ready    = 1'b1;
      default: O_arvalid     = 1'b0;
    endcase
  end

  assign O_araddr    = pc_q;
  assign O_pc        = pc_q;
  assign O_snpc      = pc_q + 32'd4;
  assign O_inst      = inst_q;
  assign O_fetch_err = err_q;

endmodule

// File: tb/tb_ysyx_040750_pc_fetch.sv
// tb_ysyx_040750_pc_fetch: directed scenarios plus a
// randomized run against a transaction-level fetch model.
module tb_ysyx_040750_pc_fetch;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic        I_pc_valid;
  logic        O_pc_ready;
  logic [31:0] I_dnpc;
  logic        I_flush;
  logic [31:0] O_araddr;
  logic        O_arvalid;
  logic        I_arready;
  logic [31:0] I_rdata;
  logic [1:0]  I_rresp;
  logic        I_rvalid;
  logic        O_rready;
  logic [31:0] O_pc;
  logic [31:0] O_snpc;
  logic [31:0] O_inst;
  logic        O_fetch_err;
  logic        O_IF_ID_valid;
  logic        I_IF_ID_ready;

  int total = 0;
  int bad = 0;

  // instruction memory model state
  bit          pend;
  logic [31:0] pend_addr;
  logic [1:0]  pend_resp;
  logic [1:0]  mem_resp;
  int          ar_cnt, rcnt, ar_dly, r_dly;
  bit          rnd_mem;

  always #5 I_clk = ~I_clk;

  ysyx_040750_pc_fetch u_dut (
    .I_clk         (I_clk),
    .I_rst_n       (I_rst_n),
    .I_pc_valid    (I_pc_valid),
    .O_pc_ready    (O_pc_ready),
    .I_dnpc        (I_dnpc),
    .I_flush       (I_flush),
    .O_araddr      (O_araddr),
    .O_arvalid     (O_arvalid),
    .I_arready     (I_arready),
    .I_rdata       (I_rdata),
    .I_rresp       (I_rresp),
    .I_rvalid      (I_rvalid),
    .O_rready      (O_rready),
    .O_pc          (O_pc),
    .O_snpc        (O_snpc),
    .O_inst        (O_inst),
    .O_fetch_err   (O_fetch_err),
    .O_IF_ID_valid (O_IF_ID_valid),
    .I_IF_ID_ready (I_IF_ID_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:24], a[15:8], a[23:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic drive_mem();
    I_arready = (ar_cnt >= ar_dly);
    I_rvalid  = pend && (rcnt >= r_dly);
    I_rdata   = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    I_rresp   = pend ? pend_resp : 2'b11;
  endtask

  task automatic mem_reset();
    pend   = 1'b0;
    ar_cnt = 0;
    rcnt   = 0;
    drive_mem();
  endtask

  task automatic step();
    bit          ar_v, ar_hs, r_hs;
    logic [31:0] a;
    ar_v  = O_arvalid;
    ar_hs = O_arvalid && I_arready;
    r_hs  = O_rready && I_rvalid;
    a     = O_araddr;
    @(posedge I_clk);
    #1;
    if (r_hs) pend = 1'b0;
    if (pend) rcnt++;
    if (ar_hs) begin
      pend      = 1'b1;
      pend_addr = a;
      rcnt      = 0;
      ar_cnt    = 0;
      pend_resp = mem_resp;
      if (rnd_mem) begin
        r_dly  = $urandom_range(0, 3);
        ar_dly = $urandom_range(0, 2);
        pend_resp = ($urandom_range(0, 7) == 0)
                  ? 2'($urandom_range(1, 3)) : 2'b00;
      end
    end else if (ar_v) begin
      ar_cnt++;
    end
    drive_mem();
  endtask

  task automatic issue(input logic [31:0] a);
    I_pc_valid = 1'b1;
    I_dnpc     = a;
    step();
    I_pc_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (O_IF_ID_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    total++;
    if ({O_IF_ID_valid, O_pc_ready, O_rready} !== 3'b000) begin
      bad++;
      $display("FAIL reset_valids: got %b want 000",
               {O_IF_ID_valid, O_pc_ready, O_rready});
    end
    total++;
    if (O_pc !== 32'h8000_0000 || O_inst !== 32'h0 ||
        O_fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: got pc=%h inst=%h err=%b want 80000000/0/0",
               O_pc, O_inst, O_fetch_err);
    end
    I_rst_n = 1'b1;
    #1;
    total++;
    if (O_arvalid !== 1'b1 || O_araddr !== 32'h8000_0000) begin
      bad++;
      $display("FAIL reset_ar: got v=%b a=%h want 1/80000000",
               O_arvalid, O_araddr);
    end
  endtask

  task automatic test_basic();
    I_IF_ID_ready = 1'b1;
    step();
    total++;
    if (O_rready !== 1'b1 || O_IF_ID_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_wait: got rready=%b valid=%b want 1/0",
               O_rready, O_IF_ID_valid);
    end
    step();
    total++;
    if (O_IF_ID_valid !== 1'b1 || O_pc !== 32'h8000_0000 ||
        O_snpc !== 32'h8000_0004 ||
        O_inst !== mem_word(32'h8000_0000) || O_fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_out: got v=%b pc=%h snpc=%h inst=%h err=%b want 1/80000000/80000004/%h/0",
               O_IF_ID_valid, O_pc, O_snpc, O_inst, O_fetch_err,
               mem_word(32'h8000_0000));
    end
    step();
    total++;
    if (O_pc_ready !== 1'b1 || O_IF_ID_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_next: got pc_ready=%b valid=%b want 1/0",
               O_pc_ready, O_IF_ID_valid);
    end
    issue(32'h8000_0004);
    total++;
    if (O_arvalid !== 1'b1 || O_araddr !== 32'h8000_0004 ||
        O_pc_ready !== 1'b0) begin
      bad++;
      $display("FAIL lat_req: got v=%b a=%h prdy=%b want 1/80000004/0",
               O_arvalid, O_araddr, O_pc_ready);
    end
    step();
    step();
    total++;
    if (O_IF_ID_valid !== 1'b1 || O_pc !== 32'h8000_0004) begin
      bad++;
      $display("FAIL lat_out: got v=%b pc=%h want 1/80000004",
               O_IF_ID_valid, O_pc);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    I_IF_ID_ready = 1'b0;
    issue(32'h8000_0008);
    wait_out(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_timeout: got no valid want valid");
    end
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (O_IF_ID_valid !== 1'b1 || O_pc !== 32'h8000_0008 ||
          O_inst !== mem_word(32'h8000_0008) || O_pc_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: got v=%b pc=%h inst=%h prdy=%b want 1/80000008/%h/0",
                 O_IF_ID_valid, O_pc, O_inst, O_pc_ready,
                 mem_word(32'h8000_0008));
      end
    end
    I_IF_ID_ready = 1'b1;
    step();
    total++;
    if (O_pc_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got prdy=%b want 1", O_pc_ready);
    end
    issue(32'h8000_0010);
    wait_out(ok);
    total++;
    if (!ok || O_pc !== 32'h8000_0010 ||
        O_inst !== mem_word(32'h8000_0010)) begin
      bad++;
      $display("FAIL bp_next: got ok=%b pc=%h inst=%h want 1/80000010/%h",
               ok, O_pc, O_inst, mem_word(32'h8000_0010));
    end
    step();
  endtask

  task automatic test_flush_wait();
    bit ok, seen;
    r_dly = 3;
    issue(32'h8000_0040);
    step();
    total++;
    if (O_rready !== 1'b1) begin
      bad++;
      $display("FAIL fw_wait: got rready=%b want 1", O_rready);
    end
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (O_IF_ID_valid) seen = 1'b1;
      if (O_pc_ready) break;
      step();
    end
    total++;
    if (seen || O_pc_ready !== 1'b1 || pend) begin
      bad++;
      $display("FAIL fw_drop: got seen=%b prdy=%b pend=%b want 0/1/0",
               seen, O_pc_ready, pend);
    end
    r_dly = 0;
    issue(32'h8000_0100);
    wait_out(ok);
    total++;
    if (!ok || O_pc !== 32'h8000_0100 ||
        O_inst !== mem_word(32'h8000_0100)) begin
      bad++;
      $display("FAIL fw_next: got ok=%b pc=%h inst=%h want 1/80000100/%h",
               ok, O_pc, O_inst, mem_word(32'h8000_0100));
    end
    step();
  endtask

  task automatic test_flush_req();
    bit held_bad, early, seen;
    ar_dly = 4;
    r_dly  = 2;
    drive_mem();
    issue(32'h8000_0200);
    I_flush = 1'b1;
    step();
    I_flush = 1'b0;
    held_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (O_arvalid !== 1'b1 || O_araddr !== 32'h8000_0200)
        held_bad = 1'b1;
      if (I_arready) break;
      step();
    end
    step();
    total++;
    if (held_bad || !pend) begin
      bad++;
      $display("FAIL fr_hold: got held_bad=%b accepted=%b want 0/1",
               held_bad, pend);
    end
    early = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (O_pc_ready && pend) early = 1'b1;
      if (O_IF_ID_valid) seen = 1'b1;
      if (O_pc_ready) break;
      step();
    end
    total++;
    if (early || seen || O_pc_ready !== 1'b1) begin
      bad++;
      $display("FAIL fr_drop: got early=%b seen=%b prdy=%b want 0/0/1",
               early, seen, O_pc_ready);
    end
    ar_dly = 0;
    r_dly  = 0;
    drive_mem();
  endtask

  task automatic test_fault();
    bit ok;
    issue(32'h8000_0002);
    total++;
    if (O_arvalid !== 1'b0) begin
      bad++;
      $display("FAIL mis_ar: got arvalid=%b want 0", O_arvalid);
    end
    step();
    total++;
    if (O_IF_ID_valid !== 1'b1 || O_fetch_err !== 1'b1 ||
        O_inst !== 32'h0000_0013 || O_pc !== 32'h8000_0002 ||
        O_arvalid !== 1'b0) begin
      bad++;
      $display("FAIL mis_out: got v=%b err=%b inst=%h pc=%h ar=%b want 1/1/00000013/80000002/0",
               O_IF_ID_valid, O_fetch_err, O_inst, O_pc, O_arvalid);
    end
    step();
    mem_resp = 2'b10;
    issue(32'h8000_0300);
    wait_out(ok);
    total++;
    if (!ok || O_fetch_err !== 1'b1 ||
        O_inst !== mem_word(32'h8000_0300)) begin
      bad++;
      $display("FAIL bus_err: got ok=%b err=%b inst=%h want 1/1/%h",
               ok, O_fetch_err, O_inst, mem_word(32'h8000_0300));
    end
    step();
    mem_resp = 2'b00;
  endtask

  task automatic test_wrap();
    bit ok;
    issue(32'hFFFF_FFFC);
    total++;
    if (O_araddr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_addr: got %h want fffffffc", O_araddr);
    end
    wait_out(ok);
    total++;
    if (!ok || O_pc !== 32'hFFFF_FFFC || O_snpc !== 32'h0) begin
      bad++;
      $display("FAIL wrap_snpc: got ok=%b pc=%h snpc=%h want 1/fffffffc/00000000",
               ok, O_pc, O_snpc);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] cur_pc, nd, ei, sv_dnpc;
    logic [1:0]  exp_resp;
    bit          squashed, delivered, ar_done, prev_stall;
    bit          ar_hs, out_hs, pc_hs, fl, ee, aligned;
    int          age, nfetch;
    cur_pc     = 32'hFFFF_FFFC;
    exp_resp   = 2'b00;
    squashed   = 1'b0;
    delivered  = 1'b1;
    ar_done    = 1'b1;
    prev_stall = 1'b0;
    age        = 0;
    nfetch     = 0;
    rnd_mem    = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      I_IF_ID_ready = ($urandom_range(0, 3) != 0);
      I_pc_valid    = ($urandom_range(0, 2) != 0);
      nd = $urandom;
      if ($urandom_range(0, 9) != 0) nd[1:0] = 2'b00;
      I_dnpc  = nd;
      I_flush = ($urandom_range(0, 11) == 0);
      aligned = (cur_pc[1:0] == 2'b00);
      ei = aligned ? mem_word(cur_pc) : 32'h0000_0013;
      ee = aligned ? (exp_resp != 2'b00) : 1'b1;
      if (prev_stall) begin
        total++;
        if (O_arvalid !== 1'b1) begin
          bad++;
          $display("FAIL rnd_ar_hold: got arvalid=%b want 1", O_arvalid);
        end
      end
      if (O_arvalid) begin
        total++;
        if (O_araddr !== cur_pc || !aligned || ar_done) begin
          bad++;
          $display("FAIL rnd_ar: got a=%h want %h (aligned, once)",
                   O_araddr, cur_pc);
        end
      end
      if (O_IF_ID_valid) begin
        total++;
        if (squashed || delivered || O_pc !== cur_pc ||
            O_snpc !== cur_pc + 32'd4 || O_inst !== ei ||
            O_fetch_err !== ee || (aligned && (!ar_done || pend))) begin
          bad++;
          $display("FAIL rnd_out: got pc=%h inst=%h err=%b sq=%b want pc=%h inst=%h err=%b sq=0",
                   O_pc, O_inst, O_fetch_err, squashed, cur_pc, ei, ee);
        end
      end
      if (O_pc_ready) begin
        total++;
        if (!(delivered || squashed) ||
            (aligned && (!ar_done || pend))) begin
          bad++;
          $display("FAIL rnd_prdy: got del=%b sq=%b ar=%b pend=%b want fetch complete",
                   delivered, squashed, ar_done, pend);
        end
      end
      if (age > 200) begin
        total++;
        bad++;
        $display("FAIL rnd_timeout: got age=%0d want <=200", age);
        break;
      end
      ar_hs      = O_arvalid && I_arready;
      out_hs     = O_IF_ID_valid && I_IF_ID_ready;
      pc_hs      = O_pc_ready && I_pc_valid;
      fl         = I_flush;
      sv_dnpc    = I_dnpc;
      prev_stall = O_arvalid && !I_arready;
      step();
      if (ar_hs) begin
        ar_done  = 1'b1;
        exp_resp = pend_resp;
      end
      if (out_hs && !fl) delivered = 1'b1;
      if (fl && !delivered) squashed = 1'b1;
      if (pc_hs) begin
        cur_pc    = sv_dnpc;
        squashed  = 1'b0;
        delivered = 1'b0;
        ar_done   = 1'b0;
        age       = 0;
        nfetch++;
      end else begin
        age++;
      end
    end
    total++;
    if (nfetch < 50) begin
      bad++;
      $display("FAIL rnd_progress: got %0d fetches want >=50", nfetch);
    end
    rnd_mem       = 1'b0;
    I_flush       = 1'b0;
    I_pc_valid    = 1'b0;
    I_IF_ID_ready = 1'b1;
    ar_dly        = 0;
    r_dly         = 0;
    drive_mem();
    for (int k = 0; k < 100; k++) begin
      if (O_pc_ready && !pend) break;
      step();
    end
  endtask

  task automatic test_reset_mid();
    r_dly = 5;
    issue(32'h8000_0400);
    step();
    total++;
    if (O_rready !== 1'b1) begin
      bad++;
      $display("FAIL rm_wait: got rready=%b want 1", O_rready);
    end
    #2;
    I_rst_n = 1'b0;
    #1;
    total++;
    if ({O_IF_ID_valid, O_pc_ready, O_rready} !== 3'b000 ||
        O_pc !== 32'h8000_0000 || O_inst !== 32'h0 ||
        O_fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL rm_async: got v/p/r=%b pc=%h inst=%h err=%b want 000/80000000/0/0",
               {O_IF_ID_valid, O_pc_ready, O_rready}, O_pc, O_inst,
               O_fetch_err);
    end
    r_dly = 0;
    mem_reset();
    @(posedge I_clk);
    #1;
    @(posedge I_clk);
    #1;
    I_rst_n = 1'b1;
    #1;
    total++;
    if (O_arvalid !== 1'b1 || O_araddr !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rm_release: got v=%b a=%h want 1/80000000",
               O_arvalid, O_araddr);
    end
  endtask

  initial begin
    I_rst_n       = 1'b0;
    I_pc_valid    = 1'b0;
    I_dnpc        = 32'h0;
    I_flush       = 1'b0;
    I_IF_ID_ready = 1'b0;
    rnd_mem       = 1'b0;
    mem_resp      = 2'b00;
    pend_resp     = 2'b00;
    pend_addr     = 32'h0;
    ar_dly        = 0;
    r_dly         = 0;
    mem_reset();
    repeat (3) @(posedge I_clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_wait();
    test_flush_req();
    test_fault();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
